// File: rtl/vga_scan_pkg.sv
// Shared definitions for the VGA scan controller: standard mode timings,
// the totals helper and the colour width shared with the display RAM.
package vga_scan_pkg;

    typedef struct packed {
        int h_sync;
        int h_back;
        int h_active;
        int h_front;
        int v_sync;
        int v_back;
        int v_active;
        int v_front;
    } vga_mode_t;

    localparam vga_mode_t MODE_640X480_60 = '{
        h_sync: 96,  h_back: 48, h_active: 640, h_front: 16,
        v_sync: 2,   v_back: 33, v_active: 480, v_front: 10
    };

    localparam vga_mode_t MODE_800X600_60 = '{
        h_sync: 128, h_back: 88, h_active: 800, h_front: 40,
        v_sync: 4,   v_back: 23, v_active: 600, v_front: 1
    };

    // Bits per colour channel; the display RAM stores {R,G,B} at this width.
    localparam int PIX_COLOR_W = 4;

    function automatic int scan_total(input int sync_w, input int back_w,
                                      input int active_w, input int front_w);
        return sync_w + back_w + active_w + front_w;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// DEPTH x WIDTH shift register with clock enable, used to align the timing
// flags with data returning from the frame RAM.
module vga_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: this is a handful of flops rather than a RAM, so every stage
            // is reset; a stale sync/de bit would otherwise reach the pins.
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else if (ce) begin
            stage_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: x/y timing, scaled framebuffer addressing and
// alignment of sync, data-enable and colour to the frame RAM read latency.
module vga_scan_ctrl
    import vga_scan_pkg::*;
#(
    parameter int H_SYNC      = MODE_640X480_60.h_sync,
    parameter int H_BACK      = MODE_640X480_60.h_back,
    parameter int H_ACTIVE    = MODE_640X480_60.h_active,
    parameter int H_FRONT     = MODE_640X480_60.h_front,
    parameter int V_SYNC      = MODE_640X480_60.v_sync,
    parameter int V_BACK      = MODE_640X480_60.v_back,
    parameter int V_ACTIVE    = MODE_640X480_60.v_active,
    parameter int V_FRONT     = MODE_640X480_60.v_front,
    parameter int HSYNC_POL   = 0,
    parameter int VSYNC_POL   = 0,
    parameter int SCALE_SHIFT = 0,
    parameter int RD_LATENCY  = 1,
    parameter int ADDR_W      = 19,
    parameter int COLOR_W     = PIX_COLOR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pix_ce,
    output logic                 rd_en,
    output logic [ADDR_W-1:0]    rd_addr,
    input  logic [3*COLOR_W-1:0] rd_data,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 de,
    output logic [COLOR_W-1:0]   vga_r,
    output logic [COLOR_W-1:0]   vga_g,
    output logic [COLOR_W-1:0]   vga_b,
    output logic                 frame_start,
    output logic                 line_start
);

    localparam int H_TOTAL = scan_total(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
    localparam int V_TOTAL = scan_total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);
    localparam int XW      = $clog2(H_TOTAL + 1);
    localparam int YW      = $clog2(V_TOTAL + 1);
    localparam int SRC_W   = H_ACTIVE >> SCALE_SHIFT;
    localparam int SRC_H   = V_ACTIVE >> SCALE_SHIFT;
    localparam int BLK     = 1 << SCALE_SHIFT;

    localparam logic [XW-1:0] X_SYNC_END = XW'(H_SYNC);
    localparam logic [XW-1:0] X_START    = XW'(H_SYNC + H_BACK);
    localparam logic [XW-1:0] X_END      = XW'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [XW-1:0] X_LAST_ACT = XW'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [XW-1:0] X_WRAP     = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] X_MASK     = XW'(BLK - 1);
    localparam logic [YW-1:0] Y_SYNC_END = YW'(V_SYNC);
    localparam logic [YW-1:0] Y_START    = YW'(V_SYNC + V_BACK);
    localparam logic [YW-1:0] Y_END      = YW'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [YW-1:0] Y_WRAP     = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] Y_MASK     = YW'(BLK - 1);

    localparam logic [ADDR_W-1:0] A_SRC_W = ADDR_W'(SRC_W);
    localparam logic HS_ACTIVE_LVL = (HSYNC_POL != 0);
    localparam logic VS_ACTIVE_LVL = (VSYNC_POL != 0);

    localparam longint FB_WORDS = longint'(SRC_W) * longint'(SRC_H);

    // Illegal parameter sets stop elaboration rather than producing a
    // silently wrong image.
    if (SCALE_SHIFT < 0 || SCALE_SHIFT > 3) begin : g_bad_scale
        $error("vga_scan_ctrl: SCALE_SHIFT must be 0..3");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $error("vga_scan_ctrl: RD_LATENCY must be 1..4");
    end
    if ((H_ACTIVE % BLK) != 0 || (V_ACTIVE % BLK) != 0) begin : g_bad_divide
        $error("vga_scan_ctrl: active area not divisible by 2**SCALE_SHIFT");
    end
    if (FB_WORDS > (longint'(1) << ADDR_W)) begin : g_bad_addr_w
        $error("vga_scan_ctrl: source image does not fit in ADDR_W");
    end

    // ---------------------------------------------------------------- counters
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          x_wrap;
    logic          y_wrap;

    assign x_wrap = (x == X_WRAP);
    assign y_wrap = (y == Y_WRAP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (pix_ce) begin
            // NOTE: non-blocking updates so x and y both see pre-edge values.
            if (x_wrap) begin
                x <= '0;
                y <= y_wrap ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    logic sync_h;
    logic sync_v;
    logic h_act;
    logic v_act;
    logic active;
    logic at_origin;

    assign sync_h    = (x < X_SYNC_END);
    assign sync_v    = (y < Y_SYNC_END);
    assign h_act     = (x >= X_START) && (x < X_END);
    assign v_act     = (y >= Y_START) && (y < Y_END);
    assign active    = h_act && v_act;
    assign at_origin = (x == '0) && (y == '0);

    // Strobes are qualified by pix_ce so a consumer sees exactly one clock.
    assign frame_start = pix_ce && !rst && at_origin;
    assign line_start  = pix_ce && !rst && (x == '0);

    // ------------------------------------------------------- source addressing
    logic [XW-1:0]     col;
    logic [YW-1:0]     row;
    logic              col_blk_end;
    logic              row_blk_end;
    logic [ADDR_W-1:0] line_base;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] next_ptr;
    logic              base_step;

    assign col         = x - X_START;
    assign row         = y - Y_START;
    assign col_blk_end = ((col & X_MASK) == X_MASK);
    assign row_blk_end = ((row & Y_MASK) == Y_MASK);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        cur_addr  = ptr;
        next_ptr  = ptr;
        base_step = 1'b0;
        if (x == X_START) begin
            cur_addr = line_base;
        end
        if (active) begin
            next_ptr  = col_blk_end ? cur_addr + ADDR_W'(1) : cur_addr;
            base_step = (x == X_LAST_ACT) && row_blk_end;
        end
    end

    // Stage 1: read request registered from the counter stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_base <= '0;
            ptr       <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
        end else if (pix_ce) begin
            if (at_origin) begin
                line_base <= '0;
            end else if (base_step) begin
                line_base <= line_base + A_SRC_W;
            end
            ptr   <= next_ptr;
            rd_en <= active;
            if (active) begin
                rd_addr <= cur_addr;
            end
        end
    end

    // ------------------------------------------------------- alignment / pins
    logic sync_h_d;
    logic sync_v_d;
    logic active_d;

    vga_delay_line #(
        .DEPTH (RD_LATENCY + 1),
        .WIDTH (3)
    ) u_align (
        .clk  (clk),
        .rst  (rst),
        .ce   (pix_ce),
        .din  ({sync_h, sync_v, active}),
        .dout ({sync_h_d, sync_v_d, active_d})
    );

    logic [3*COLOR_W-1:0] rgb_q;

    // Output stage lands RD_LATENCY+2 strobes after the counter state, the
    // same strobe in which the RAM data for that pixel is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync <= ~HS_ACTIVE_LVL;
            vsync <= ~VS_ACTIVE_LVL;
            de    <= 1'b0;
            rgb_q <= '0;
        end else if (pix_ce) begin
            hsync <= ~(sync_h_d ^ HS_ACTIVE_LVL);
            vsync <= ~(sync_v_d ^ VS_ACTIVE_LVL);
            de    <= active_d;
            rgb_q <= active_d ? rd_data : '0;
        end
    end

    assign vga_r = rgb_q[3*COLOR_W-1:2*COLOR_W];
    assign vga_g = rgb_q[2*COLOR_W-1:COLOR_W];
    assign vga_b = rgb_q[COLOR_W-1:0];

endmodule
